// File: rtl/sqrt_pkg.sv
// Shared definitions for the sqrt / sqrt_reconstruct pair: default widths,
// FSM state encoding and the width of the final reconstruct sum.
package sqrt_pkg;

    localparam int Q_WIDTH = 11;
    localparam int R_WIDTH = 12;
    localparam int WIDTH   = 21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // One bit wider than the larger addend, so q*q + rem never wraps.
    function automatic int sum_width(input int qw, input int rw);
        return ((2 * qw > rw) ? 2 * qw : rw) + 1;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Sequential Q_WIDTH x Q_WIDTH squarer core: one multiplier bit per step,
// full 2*Q_WIDTH-bit accumulator. done_o marks the step that consumes the last bit.
module shift_add_mul
    import sqrt_pkg::*;
#(
    parameter int Q_WIDTH = sqrt_pkg::Q_WIDTH
) (
    input  logic                   clk_main,
    input  logic                   sys_rst_n,
    input  logic                   start_i,
    input  logic                   step_i,
    input  logic [Q_WIDTH-1:0]     a_i,
    output logic [2*Q_WIDTH-1:0]   acc_o,
    output logic                   done_o
);

    localparam int CW = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*Q_WIDTH-1:0]   acc_q, acc_d;
    logic [2*Q_WIDTH-1:0]   a_ext;

    assign a_ext = {{Q_WIDTH{1'b0}}, a_i};

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (step_i) begin
            if (a_i[cnt_q]) begin
                acc_d = acc_q + (a_ext << cnt_q);
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_main or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o  = acc_q;
    assign done_o = step_i && (cnt_q == CW'(Q_WIDTH - 1));

endmodule

// File: rtl/sqrt_reconstruct.sv
// Rebuilds radical = q*q + rem from a sqrt root/remainder pair, flagging
// illegal remainders and results that do not fit in WIDTH bits.
//
//   state   | meaning
//   IDLE    | ready for an operand pair
//   MUL     | squaring q, one bit per cycle
//   ADD     | adding remainder, registering result and flags
//   DONE    | result presented, waiting for out_ready
module sqrt_reconstruct
    import sqrt_pkg::*;
#(
    parameter int Q_WIDTH = sqrt_pkg::Q_WIDTH,
    parameter int R_WIDTH = sqrt_pkg::R_WIDTH,
    parameter int WIDTH   = sqrt_pkg::WIDTH
) (
    input  logic                 clk_main,
    input  logic                 sys_rst_n,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Q_WIDTH-1:0]   q_in,
    input  logic [R_WIDTH-1:0]   rem_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     radical_out,
    output logic                 err_rem,
    output logic                 err_ovf
);

    localparam int SW = sum_width(Q_WIDTH, R_WIDTH);

    state_e                 state_q, state_d;
    logic [Q_WIDTH-1:0]     q_q, q_d;
    logic [R_WIDTH-1:0]     rem_q, rem_d;
    logic                   err_rem_r_q, err_rem_r_d;
    logic [WIDTH-1:0]       radical_q, radical_d;
    logic                   err_rem_q, err_rem_d;
    logic                   err_ovf_q, err_ovf_d;
    logic                   out_valid_q, out_valid_d;
    logic                   live_q;

    logic                   accept;
    logic                   mul_step;
    logic                   mul_done;
    logic [2*Q_WIDTH-1:0]   acc;
    logic [SW-1:0]          sum;
    logic [R_WIDTH:0]       q2_ext;
    logic                   rem_gt;

    // live_q keeps in_ready low until the first edge after reset release.
    assign in_ready = (state_q == ST_IDLE) && live_q;
    assign accept   = ena && in_valid && in_ready;
    assign mul_step = ena && (state_q == ST_MUL);

    assign q2_ext = (R_WIDTH + 1)'({q_in, 1'b0});
    assign rem_gt = {1'b0, rem_in} > q2_ext;
    assign sum    = SW'(acc) + SW'(rem_q);

    shift_add_mul #(
        .Q_WIDTH (Q_WIDTH)
    ) u_mul (
        .clk_main  (clk_main),
        .sys_rst_n (sys_rst_n),
        .start_i   (accept),
        .step_i    (mul_step),
        .a_i       (q_q),
        .acc_o     (acc),
        .done_o    (mul_done)
    );

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        rem_d       = rem_q;
        err_rem_r_d = err_rem_r_q;
        radical_d   = radical_q;
        err_rem_d   = err_rem_q;
        err_ovf_d   = err_ovf_q;
        out_valid_d = out_valid_q;
        if (ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        q_d         = q_in;
                        rem_d       = rem_in;
                        err_rem_r_d = rem_gt;
                        state_d     = ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_d = ST_ADD;
                    end
                end
                ST_ADD: begin
                    radical_d   = sum[WIDTH-1:0];
                    err_ovf_d   = |sum[SW-1:WIDTH];
                    err_rem_d   = err_rem_r_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_main or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            rem_q       <= '0;
            err_rem_r_q <= 1'b0;
            radical_q   <= '0;
            err_rem_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            err_rem_r_q <= err_rem_r_d;
            radical_q   <= radical_d;
            err_rem_q   <= err_rem_d;
            err_ovf_q   <= err_ovf_d;
            out_valid_q <= out_valid_d;
            live_q      <= 1'b1;
        end
    end

    assign out_valid   = out_valid_q;
    assign radical_out = radical_q;
    assign err_rem     = err_rem_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// Randomised self-checking bench for sqrt_reconstruct against an arithmetic model.
module tb_sqrt_reconstruct;
    import sqrt_pkg::*;

    localparam int QW = Q_WIDTH;
    localparam int RW = R_WIDTH;
    localparam int W  = WIDTH;
    localparam int LAT = QW + 1;

    logic           clk_main = 1'b0;
    logic           sys_rst_n;
    logic           ena;
    logic           in_valid;
    logic           in_ready;
    logic [QW-1:0]  q_in;
    logic [RW-1:0]  rem_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   radical_out;
    logic           err_rem;
    logic           err_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_main = ~clk_main;

    sqrt_reconstruct dut (
        .clk_main    (clk_main),
        .sys_rst_n   (sys_rst_n),
        .ena         (ena),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .q_in        (q_in),
        .rem_in      (rem_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .radical_out (radical_out),
        .err_rem     (err_rem),
        .err_ovf     (err_ovf)
    );

    function automatic void model(input int q, input int rem,
                                  output logic [W-1:0] rad, output logic er, output logic eo);
        longint full;
        full = longint'(q) * longint'(q) + longint'(rem);
        rad  = W'(full % (longint'(1) << W));
        eo   = full > ((longint'(1) << W) - 1);
        er   = rem > 2 * q;
    endfunction

    function automatic int isqrt(input longint v);
        longint lo, hi, mid;
        lo = 0;
        hi = 4096;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        return int'(lo);
    endfunction

    task automatic start_op(input int q, input int rem);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk_main);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL start_ready_timeout: in_ready=%b required 1", in_ready);
        end
        q_in     = QW'(q);
        rem_in   = RW'(rem);
        in_valid = 1'b1;
        @(negedge clk_main);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk_main);
            lat++;
        end
        if (out_valid !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout: out_valid=%b after %0d cycles", out_valid, lat);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk_main);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; q_in = '0; rem_in = '0;
        repeat (3) @(negedge clk_main);
        n_vec++;
        if ({in_ready, out_valid, radical_out, err_rem, err_ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b ov=%b rad=%0d er=%b eo=%b required all 0",
                     in_ready, out_valid, radical_out, err_rem, err_ovf);
        end
        sys_rst_n = 1'b1;
        @(negedge clk_main);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        int lat;
        start_op(3, 2);
        wait_result(lat);
        n_vec++;
        if (lat != LAT || radical_out !== W'(11) || err_rem !== 1'b0 || err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL basic_3_2: lat=%0d rad=%0d er=%b eo=%b required lat=%0d rad=11 flags 0",
                     lat, radical_out, err_rem, err_ovf, LAT);
        end
        release_out();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_boundaries();
        int qs[6]    = '{1448, 1448, 5, 0, 2047, 0};
        int rs[6]    = '{447, 448, 11, 0, 4095, 4095};
        int lat;
        logic [W-1:0] e_rad;
        logic e_er, e_eo;
        for (int i = 0; i < 6; i++) begin
            model(qs[i], rs[i], e_rad, e_er, e_eo);
            start_op(qs[i], rs[i]);
            wait_result(lat);
            n_vec++;
            if (lat != LAT || radical_out !== e_rad || err_rem !== e_er || err_ovf !== e_eo) begin
                n_err++;
                $display("FAIL boundary q=%0d rem=%0d: lat=%0d rad=%0d er=%b eo=%b required lat=%0d rad=%0d er=%b eo=%b",
                         qs[i], rs[i], lat, radical_out, err_rem, err_ovf, LAT, e_rad, e_er, e_eo);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        start_op(5, 11);
        wait_result(lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; q_in = QW'(7); rem_in = RW'(1);
            @(negedge clk_main);
            n_vec++;
            if (out_valid !== 1'b1 || radical_out !== W'(36) || err_rem !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: ov=%b rad=%0d er=%b rdy=%b required 1/36/1/0",
                         i, out_valid, radical_out, err_rem, in_ready);
            end
        end
        in_valid = 1'b0;
        release_out();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || radical_out !== W'(36)) begin
            n_err++;
            $display("FAIL backpressure_release: rdy=%b ov=%b rad=%0d required 1/0/36",
                     in_ready, out_valid, radical_out);
        end
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk_main);
            if (out_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure_ignored_input: out_valid seen %0d cycles required 0", bad);
        end
    endtask

    task automatic test_ena();
        int lat;
        start_op(1000, 7);
        repeat (3) @(negedge clk_main);
        ena = 1'b0;
        repeat (3) @(negedge clk_main);
        ena = 1'b1;
        wait_result(lat);
        n_vec++;
        if (lat + 6 != LAT + 3 || radical_out !== W'(1000007) || err_rem !== 1'b0 || err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ena_stall: lat=%0d rad=%0d er=%b eo=%b required lat=%0d rad=1000007 flags 0",
                     lat + 6, radical_out, err_rem, err_ovf, LAT + 3);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        int bad;
        start_op(100, 50);
        repeat (4) @(negedge clk_main);
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, radical_out, err_rem, err_ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: rdy=%b ov=%b rad=%0d er=%b eo=%b required all 0",
                     in_ready, out_valid, radical_out, err_rem, err_ovf);
        end
        @(negedge clk_main);
        sys_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk_main);
            if (out_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_mid_spurious: out_valid seen %0d cycles required 0", bad);
        end
        start_op(1234, 2000);
        wait_result(lat);
        n_vec++;
        if (lat != LAT || radical_out !== W'(1524756) || err_rem !== 1'b0 || err_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_next_op: lat=%0d rad=%0d er=%b eo=%b required lat=%0d rad=1524756 flags 0",
                     lat, radical_out, err_rem, err_ovf, LAT);
        end
        release_out();
    endtask

    task automatic test_random();
        int q, rem, lat, dly;
        logic [W-1:0] e_rad;
        logic e_er, e_eo;
        for (int i = 0; i < 200; i++) begin
            q   = int'($urandom_range(0, (1 << QW) - 1));
            rem = int'($urandom_range(0, (1 << RW) - 1));
            if (i % 3 == 0) rem = int'($urandom_range(0, 2 * q));
            model(q, rem, e_rad, e_er, e_eo);
            start_op(q, rem);
            wait_result(lat);
            dly = int'($urandom_range(0, 3));
            repeat (dly) @(negedge clk_main);
            n_vec++;
            if (lat != LAT || radical_out !== e_rad || err_rem !== e_er || err_ovf !== e_eo) begin
                n_err++;
                $display("FAIL random q=%0d rem=%0d: lat=%0d rad=%0d er=%b eo=%b required lat=%0d rad=%0d er=%b eo=%b",
                         q, rem, lat, radical_out, err_rem, err_ovf, LAT, e_rad, e_er, e_eo);
            end
            release_out();
        end
    endtask

    task automatic test_round_trip();
        longint data;
        int q, rem, lat;
        for (int a = 1; a <= 1000; a++) begin
            data = longint'(a) * longint'(a) + 3;
            q    = isqrt(data);
            rem  = int'(data - longint'(q) * longint'(q));
            start_op(q, rem);
            wait_result(lat);
            n_vec++;
            if (radical_out !== W'(data) || err_rem !== 1'b0 || err_ovf !== 1'b0) begin
                n_err++;
                $display("FAIL round_trip a=%0d: rad=%0d er=%b eo=%b required rad=%0d flags 0",
                         a, radical_out, err_rem, err_ovf, data);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_ena();
        test_reset_mid();
        test_random();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
